// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad digit transmitter: FSM states, key map,
// matrix dimensions and small decode helpers.
package keypad_pkg;

   localparam int ROW_W = 4;
   localparam int COL_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DEBOUNCE,
      ST_EMIT,
      ST_HELD,
      ST_RELEASE
   } state_e;

   // Code for each key, indexed by {row, col}; element 0 is row 0 / col 0.
   // '*' encodes as E and '#' as F.
   localparam logic [15:0][3:0] KEY_MAP = {
      4'hD, 4'hF, 4'h0, 4'hE,   // row 3, col 3..0
      4'hC, 4'h9, 4'h8, 4'h7,   // row 2
      4'hB, 4'h6, 4'h5, 4'h4,   // row 1
      4'hA, 4'h3, 4'h2, 4'h1    // row 0
   };

   typedef struct packed {
      logic       hit;   // exactly one column is low
      logic [1:0] idx;   // index of that column
   } col_hit_t;

   // Accept only a single low column; none or several (ghosting) is no hit.
   function automatic col_hit_t col_decode(input logic [COL_W-1:0] col_s);
      col_hit_t res;
      // NOTE: give the result a default before the case so no path leaves it unassigned.
      res = '0;
      case (col_s)
         4'b1110: res = '{1'b1, 2'd0};
         4'b1101: res = '{1'b1, 2'd1};
         4'b1011: res = '{1'b1, 2'd2};
         4'b0111: res = '{1'b1, 2'd3};
         default: res = '0;
      endcase
      return res;
   endfunction

   // Active-low one-hot drive pattern for the given row.
   function automatic logic [ROW_W-1:0] row_drive(input logic [1:0] row);
      return ~(ROW_W'(1) << row);
   endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous keypad column inputs.
// Resets to all-high, the idle (no key) column level.
module keypad_sync
   import keypad_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [COL_W-1:0] col_n_i,
   output logic [COL_W-1:0] col_s_o
);

   logic [COL_W-1:0] meta_q;
   logic [COL_W-1:0] sync_q;

   // Double-register the raw columns before any decision uses them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         // NOTE: non-blocking so each flop takes the value from before the edge.
         meta_q <= col_n_i;
         sync_q <= meta_q;
      end
   end

   assign col_s_o = sync_q;

endmodule

// File: rtl/keypad_digit_tx.sv
// 4x4 keypad scanner, debouncer and digit encoder. Each accepted press gives
// a one-cycle key_valid strobe with the mapped code on key_digit.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-emit the held key every
// REPEAT_DLY cycles; without it exactly one strobe is produced per press.
module keypad_digit_tx
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV   = 16,
   parameter int DEBOUNCE   = 1000,
   parameter int REPEAT_DLY = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             scan_en,
   input  logic [COL_W-1:0] col_n,
   output logic [ROW_W-1:0] row_n,
   output logic [3:0]       key_digit,
   output logic             key_valid,
   output logic             key_held
);

   localparam int SCW = $clog2(SCAN_DIV) + 1;
   localparam int DBW = $clog2(DEBOUNCE) + 1;
   localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
   localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE - 1);

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int RPW = $clog2(REPEAT_DLY) + 1;
   // HELD is entered one cycle after the strobe, so the repeat fires two
   // counts early to land exactly REPEAT_DLY cycles after the previous one.
   localparam logic [RPW-1:0] REP_LAST = RPW'(REPEAT_DLY - 2);
   logic [RPW-1:0] rep_q;
`else
   // Repeat interval is meaningless without auto-repeat.
   logic unused_repeat;
   assign unused_repeat = ^REPEAT_DLY;
`endif

   logic [COL_W-1:0] col_s;
   col_hit_t         col_hit;

   state_e           state_q;
   logic [1:0]       row_q;
   logic [1:0]       col_idx_q;
   logic [COL_W-1:0] pat_q;
   logic [SCW-1:0]   scan_cnt_q;
   logic [DBW-1:0]   cnt_q;
   logic [ROW_W-1:0] row_n_q;
   logic [3:0]       key_digit_q;
   logic             key_valid_q;
   logic             key_held_q;

   keypad_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .col_n_i (col_n),
      .col_s_o (col_s)
   );

   assign col_hit = col_decode(col_s);

   // Scan / debounce / emit / release state machine with registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         row_q       <= 2'd0;
         col_idx_q   <= 2'd0;
         pat_q       <= '1;
         scan_cnt_q  <= '0;
         cnt_q       <= '0;
         row_n_q     <= '1;
         key_digit_q <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_q       <= '0;
`endif
      end else begin
         // NOTE: strobe defaults low here; only the entries into EMIT raise it.
         key_valid_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_q       <= '0;
`endif
         if (!scan_en) begin
            state_q    <= ST_IDLE;
            row_n_q    <= '1;
            key_held_q <= 1'b0;
            scan_cnt_q <= '0;
            cnt_q      <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_q    <= ST_SCAN;
                  row_q      <= 2'd0;
                  row_n_q    <= row_drive(2'd0);
                  scan_cnt_q <= '0;
               end

               ST_SCAN: begin
                  if (scan_cnt_q == SCAN_LAST) begin
                     scan_cnt_q <= '0;
                     if (col_hit.hit) begin
                        pat_q     <= col_s;
                        col_idx_q <= col_hit.idx;
                        cnt_q     <= '0;
                        state_q   <= ST_DEBOUNCE;
                     end else begin
                        row_q   <= row_q + 2'd1;
                        row_n_q <= row_drive(row_q + 2'd1);
                     end
                  end else begin
                     scan_cnt_q <= scan_cnt_q + SCW'(1);
                  end
               end

               ST_DEBOUNCE: begin
                  if (col_s != pat_q) begin
                     state_q    <= ST_SCAN;
                     scan_cnt_q <= '0;
                     row_q      <= row_q + 2'd1;
                     row_n_q    <= row_drive(row_q + 2'd1);
                  end else if (cnt_q == DB_LAST) begin
                     state_q     <= ST_EMIT;
                     key_valid_q <= 1'b1;
                     key_digit_q <= KEY_MAP[{row_q, col_idx_q}];
                  end else begin
                     cnt_q <= cnt_q + DBW'(1);
                  end
               end

               ST_EMIT: begin
                  state_q    <= ST_HELD;
                  key_held_q <= 1'b1;
               end

               ST_HELD: begin
                  if (col_s == '1) begin
                     state_q <= ST_RELEASE;
                     cnt_q   <= '0;
                  end
`ifdef KEYPAD_AUTOREPEAT_EN
                  else if (rep_q == REP_LAST) begin
                     state_q     <= ST_EMIT;
                     key_valid_q <= 1'b1;
                     key_digit_q <= KEY_MAP[{row_q, col_idx_q}];
                  end else begin
                     rep_q <= rep_q + RPW'(1);
                  end
`endif
               end

               ST_RELEASE: begin
                  if (col_s != '1) begin
                     state_q <= ST_HELD;
                     cnt_q   <= '0;
                  end else if (cnt_q == DB_LAST) begin
                     state_q    <= ST_SCAN;
                     key_held_q <= 1'b0;
                     row_q      <= 2'd0;
                     row_n_q    <= row_drive(2'd0);
                     scan_cnt_q <= '0;
                  end else begin
                     cnt_q <= cnt_q + DBW'(1);
                  end
               end

               default: begin
                  state_q <= ST_IDLE;
                  row_n_q <= '1;
               end
            endcase
         end
      end
   end

   assign row_n     = row_n_q;
   assign key_digit = key_digit_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_digit_tx.sv
// Directed testbench for keypad_digit_tx with a 4x4 switch-matrix model.
module tb_keypad_digit_tx;
   import keypad_pkg::*;

   localparam int SCAN_DIV   = 4;
   localparam int DEBOUNCE   = 8;
   localparam int REPEAT_DLY = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       scan_en = 1'b0;
   logic [3:0] col_n;
   logic [3:0] row_n;
   logic [3:0] key_digit;
   logic       key_valid;
   logic       key_held;

   logic [15:0] pressed = '0;   // bit row*4+col closes that switch
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          consec_err = 0;
   logic        prev_valid = 1'b0;
   logic [3:0]  strobe_dig[$];
   int          strobe_cyc[$];

   keypad_digit_tx #(
      .SCAN_DIV   (SCAN_DIV),
      .DEBOUNCE   (DEBOUNCE),
      .REPEAT_DLY (REPEAT_DLY)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .scan_en   (scan_en),
      .col_n     (col_n),
      .row_n     (row_n),
      .key_digit (key_digit),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   // Switch matrix: a closed switch pulls its column low while its row is driven.
   always_comb begin
      col_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (key_valid && prev_valid) consec_err <= consec_err + 1;
      prev_valid <= key_valid;
   end

   task automatic clear_log();
      strobe_dig.delete();
      strobe_cyc.delete();
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(negedge clk);
         if (key_valid) begin
            strobe_dig.push_back(key_digit);
            strobe_cyc.push_back(cyc);
         end
      end
   endtask

   // Park at the first cycle of a fresh row-0 scan window.
   task automatic wait_row0_start();
      int n;
      n = 0;
      while (row_n === 4'b1110 && n < 40) begin @(negedge clk); n++; end
      while (row_n !== 4'b1110 && n < 80) begin @(negedge clk); n++; end
      checks++;
      if (n >= 80) begin
         errors++;
         $display("FAIL row0_wait: got row_n %b after %0d cycles, required 1110", row_n, n);
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp_row;
      int n;
      rst = 1'b0; scan_en = 1'b1; pressed = '0;
      repeat (3) @(negedge clk);
      checks++; if (row_n !== 4'hF) begin errors++; $display("FAIL reset_row_n: got %b required 1111", row_n); end
      checks++; if (key_digit !== 4'h0) begin errors++; $display("FAIL reset_digit: got %h required 0", key_digit); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", key_valid); end
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b required 0", key_held); end
      rst = 1'b1;
      n = 0;
      @(negedge clk);
      checks++; if (row_n !== 4'b1110) begin errors++; $display("FAIL first_row: got %b required 1110", row_n); end
      while (row_n !== 4'b1110 && n < 10) begin @(negedge clk); n++; end
      for (int i = 0; i < 16; i++) begin
         exp_row = 4'b1111 ^ (4'b0001 << (i / 4));
         checks++;
         if (row_n !== exp_row || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL scan_seq[%0d]: got row_n %b valid %b, required %b valid 0", i, row_n, key_valid, exp_row);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_single_press();
      clear_log();
      pressed[4] = 1'b1;   // row 1, col 0 -> '4'
      run(60);
      checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL held_while_pressed: got %b required 1", key_held); end
      pressed = '0;
      run(10);
      checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL held_before_release_done: got %b required 1", key_held); end
      run(1);
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL held_after_release: got %b required 0", key_held); end
      checks++;
      if (strobe_dig.size() != 1) begin
         errors++; $display("FAIL single_count: got %0d strobes required 1", strobe_dig.size());
      end else if (strobe_dig[0] !== 4'h4) begin
         errors++; $display("FAIL single_digit: got %h required 4", strobe_dig[0]);
      end
      run(20);
   endtask

   task automatic test_password();
      int          key_idx[4];
      logic [3:0]  exp_dig[4];
      logic [15:0] pass;
      key_idx = '{4, 2, 1, 0};           // keys 4, 3, 2, 1
      exp_dig = '{4'h4, 4'h3, 4'h2, 4'h1};
      pass = 16'h0000;
      for (int k = 0; k < 4; k++) begin
         clear_log();
         pressed[key_idx[k]] = 1'b1;
         run(60);
         pressed = '0;
         run(30);
         checks++;
         if (strobe_dig.size() != 1 || strobe_dig[0] !== exp_dig[k]) begin
            errors++;
            $display("FAIL password_digit[%0d]: got %0d strobes first %h, required 1 strobe %h",
                     k, strobe_dig.size(), (strobe_dig.size() > 0) ? strobe_dig[0] : 4'hx, exp_dig[k]);
         end
         if (strobe_dig.size() > 0) pass = {strobe_dig[0], pass[15:4]};
      end
      checks++; if (pass !== 16'h1234) begin errors++; $display("FAIL password_value: got %h required 1234", pass); end
   endtask

   task automatic test_bounce();
      clear_log();
      wait_row0_start();
      pressed[0] = 1'b1;
      run(4);
      checks++;
      if (dut.state_q !== ST_DEBOUNCE) begin errors++; $display("FAIL bounce_reached_debounce: got %0d required %0d", dut.state_q, ST_DEBOUNCE); end
      run(1);
      pressed[0] = 1'b0;
      run(2);
      pressed[0] = 1'b1;
      run(3);
      pressed[0] = 1'b0;
      run(20);
      checks++; if (strobe_dig.size() != 0) begin errors++; $display("FAIL bounce_strobe: got %0d strobes required 0", strobe_dig.size()); end
      checks++; if (dut.state_q !== ST_SCAN) begin errors++; $display("FAIL bounce_state: got %0d required %0d", dut.state_q, ST_SCAN); end
   endtask

   task automatic test_ghost();
      clear_log();
      pressed[0] = 1'b1;
      pressed[2] = 1'b1;
      wait_row0_start();
      run(4);
      checks++; if (row_n !== 4'b1101) begin errors++; $display("FAIL ghost_row_advance: got %b required 1101", row_n); end
      run(40);
      checks++; if (strobe_dig.size() != 0) begin errors++; $display("FAIL ghost_strobe: got %0d strobes required 0", strobe_dig.size()); end
      checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL ghost_held: got %b required 0", key_held); end
      pressed = '0;
      run(10);
   endtask

   task automatic test_reset_mid();
      int n;
      pressed[5] = 1'b1;   // '5'
      n = 0;
      while (!(dut.state_q == ST_DEBOUNCE && dut.cnt_q == 5) && n < 100) begin @(negedge clk); n++; end
      checks++; if (n >= 100) begin errors++; $display("FAIL reach_debounce5: got timeout after %0d cycles, required count 5", n); end
      rst = 1'b0;
      #1;
      checks++; if (row_n !== 4'hF) begin errors++; $display("FAIL midrst_row_n: got %b required 1111", row_n); end
      checks++; if (key_digit !== 4'h0) begin errors++; $display("FAIL midrst_digit: got %h required 0", key_digit); end
      checks++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin errors++; $display("FAIL midrst_flags: got valid %b held %b required 0 0", key_valid, key_held); end
      pressed = '0;
      @(negedge clk);
      rst = 1'b1;
      clear_log();
      run(60);
      checks++; if (strobe_dig.size() != 0) begin errors++; $display("FAIL midrst_strobe: got %0d strobes required 0", strobe_dig.size()); end
   endtask

   task automatic test_scan_en();
      clear_log();
      pressed[6] = 1'b1;   // '6'
      run(40);
      checks++;
      if (strobe_dig.size() != 1 || strobe_dig[0] !== 4'h6) begin
         errors++; $display("FAIL scan_en_press: got %0d strobes, required 1 strobe of 6", strobe_dig.size());
      end
      scan_en = 1'b0;
      @(negedge clk);
      checks++; if (row_n !== 4'hF || key_held !== 1'b0) begin errors++; $display("FAIL scan_en_idle: got row_n %b held %b required 1111 0", row_n, key_held); end
      clear_log();
      run(20);
      pressed = '0;
      run(5);
      scan_en = 1'b1;
      run(30);
      checks++; if (strobe_dig.size() != 0) begin errors++; $display("FAIL scan_en_strobe: got %0d strobes required 0", strobe_dig.size()); end
      checks++; if (row_n === 4'hF) begin errors++; $display("FAIL scan_en_resume: got row_n %b required a driven row", row_n); end
   endtask

   task automatic test_autorepeat();
      int n;
      int t0;
      clear_log();
      pressed[10] = 1'b1;   // '9'
      n = 0;
      while (key_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      checks++;
      if (n >= 60 || key_digit !== 4'h9) begin errors++; $display("FAIL repeat_first: got valid %b digit %h, required 1 and 9", key_valid, key_digit); end
      t0 = cyc;
      run(110);
`ifdef KEYPAD_AUTOREPEAT_EN
      checks++;
      if (strobe_dig.size() != 3) begin
         errors++; $display("FAIL repeat_count: got %0d repeats required 3", strobe_dig.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (strobe_dig[i] !== 4'h9 || strobe_cyc[i] - t0 != REPEAT_DLY * (i + 1)) begin
               errors++;
               $display("FAIL repeat[%0d]: got digit %h offset %0d, required 9 offset %0d", i, strobe_dig[i], strobe_cyc[i] - t0, REPEAT_DLY * (i + 1));
            end
         end
      end
`else
      checks++;
      if (strobe_dig.size() != 0) begin errors++; $display("FAIL no_repeat: got %0d extra strobes required 0", strobe_dig.size()); end
`endif
      pressed = '0;
      run(30);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete within the time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_press();
      test_password();
      test_bounce();
      test_ghost();
      test_reset_mid();
      test_scan_en();
      test_autorepeat();
      checks++;
      if (consec_err != 0) begin errors++; $display("FAIL consecutive_strobes: got %0d occurrences required 0", consec_err); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
